// File: rtl/cdm16_f770_mul.sv
// 16x16 unsigned carry-disregard approximate multiplier.
// Low half ORs each column; high half is an exact sum; output registered.
module cdm16_f770_mul (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [31:0] R
);

  logic [15:0] lo;
  logic [15:0] hi;
  logic [31:0] row;

  // Each row is B gated by one bit of A, shifted into place.
  // Its low 16 bits fold into the column OR, and its high bits
  // join the exact upper sum. Nothing carries across bit 15/16.
  always_comb begin
    lo  = '0;
    hi  = '0;
    row = '0;
    for (int j = 0; j < 16; j++) begin
      row = {16'b0, B & {16{A[j]}}} << j;
      lo  = lo | row[15:0];
      hi  = hi + row[31:16];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) R <= '0;
    else        R <= {hi, lo};
  end

endmodule

// File: tb/tb_cdm16_f770_mul.sv
// Scoreboard bench for cdm16_f770_mul.
// Driver queues expected results; monitor pops and compares.
module tb_cdm16_f770_mul;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] A;
  logic [15:0] B;
  logic [31:0] R;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] q_exp[$];
  longint      q_prod[$];
  string       q_name[$];

  cdm16_f770_mul dut (
    .clk  (clk),
    .rst_n(rst_n),
    .A    (A),
    .B    (B),
    .R    (R)
  );

  always #5 clk = ~clk;

  // Column c of the low half is set if any bit pair lands there;
  // pairs landing at or above 16 add their weight to the top half.
  function automatic logic [31:0] model(input logic [15:0] a,
                                        input logic [15:0] b);
    longint      hsum = 0;
    logic [15:0] lbits = '0;
    for (int j = 0; j < 16; j++)
      for (int k = 0; k < 16; k++)
        if (a[j] && b[k]) begin
          if (j + k < 16) lbits[j+k] = 1'b1;
          else hsum += longint'(1) << (j + k - 16);
        end
    return {16'(hsum % 65536), lbits};
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic issue(input string nm, input logic [15:0] a,
                       input logic [15:0] b, input logic [31:0] exp);
    @(negedge clk);
    A = a;
    B = b;
    q_exp.push_back(exp);
    q_prod.push_back(longint'(a) * longint'(b));
    q_name.push_back(nm);
  endtask

  always @(posedge clk) begin
    #1;
    if (rst_n && q_exp.size() > 0) begin
      logic [31:0] e;
      longint      p;
      string       nm;
      e  = q_exp.pop_front();
      p  = q_prod.pop_front();
      nm = q_name.pop_front();
      check(nm, R, e);
      compared++;
      if (longint'(R) > p) begin
        mismatched++;
        $display("FAIL %s_bound: got %h above exact %h", nm, R, p);
      end
    end
  end

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    rst_n = 1'b0;
    A = 16'hFFFF;
    B = 16'hFFFF;
    repeat (4) begin
      @(negedge clk);
      check("reset_hold", R, 32'h0);
    end
    rst_n = 1'b1;

    issue("one_x", 16'h0001, 16'hABCD, 32'h0000ABCD);
    issue("zero", 16'hFFFF, 16'h0000, 32'h0);
    issue("m256", 16'h0100, 16'h0100, 32'h00010000);
    issue("ff00", 16'hFF00, 16'hFF00, 32'hFE010000);
    issue("three", 16'h0003, 16'h0003, 32'h00000007);
    issue("ff_ff", 16'h00FF, 16'h00FF, 32'h00007FFF);
    issue("col15", 16'h8001, 16'h8001, 32'h40008001);
    issue("b2b_0", 16'h0003, 16'h0003, 32'h00000007);
    issue("b2b_1", 16'h0100, 16'h0100, 32'h00010000);
    issue("b2b_2", 16'h0001, 16'hFFFF, 32'h0000FFFF);
    issue("max", 16'hFFFF, 16'hFFFF, model(16'hFFFF, 16'hFFFF));

    for (int i = 0; i < 3000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 7 == 0) ra = ra & 16'h00FF;
      issue("rand", ra, rb, model(ra, rb));
    end

    for (int i = 0; i < 20 && q_exp.size() > 0; i++) @(negedge clk);
    compared++;
    if (q_exp.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d left, 0 wanted", q_exp.size());
    end

    @(negedge clk);
    A = 16'h0001;
    B = 16'hABCD;
    @(posedge clk);
    #2;
    check("pre_async", R, 32'h0000ABCD);
    rst_n = 1'b0;
    #1;
    check("async_clr", R, 32'h0);
    @(posedge clk);
    #1;
    check("async_hold", R, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    issue("post_rst", 16'h8001, 16'h8001, 32'h40008001);
    for (int i = 0; i < 5 && q_exp.size() > 0; i++) @(negedge clk);
    compared++;
    if (q_exp.size() != 0) begin
      mismatched++;
      $display("FAIL drain2: %0d left, 0 wanted", q_exp.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
